d_reg_bank: RTL
===============

# d_reg_bank

Parametrised multi-channel D register bank, the clocked successor to the single-bit D latch. It stores CH channels of WIDTH bits, each loaded by its own enable. It offers an atomic output freeze and a synchronous clear. Channels whose stored value changed are reported over a valid/ready change-notification port, selected round-robin. The block sits between producer logic and any consumer that needs stable snapshots or change events.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CH, 4, channel count (≥2); CHW = $clog2(CH)
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- EN  in  CH  per-channel write enable; EN[i] loads channel i
- D  in  CH*WIDTH  write data; channel i is D[i*WIDTH +: WIDTH]
- CLR  in  1  synchronous clear of all channels
- FREEZE  in  1  when 1, Q holds its current value
- Q  out  CH*WIDTH  registered channel outputs, same packing as D
- DIRTY  out  CH  sticky per-channel change flags
- OUT_VALID  out  1  change notification valid
- OUT_CH  out  CHW  channel index being reported
- OUT_DATA  out  WIDTH  stored value of OUT_CH at selection time
- OUT_READY  in  1  consumer accepts notification

## Operation
- Internal store R[i], Q register, DIRTY[i], round-robin pointer PTR (CHW bits), FSM {IDLE, PRESENT}, flag REW.
- Reset (RST_N=0, asynchronous): R, Q, DIRTY, PTR, OUT_CH, OUT_DATA = 0; OUT_VALID = 0; FSM = IDLE; REW = 0.
- Priority on each edge: CLR, then EN writes.
  - CLR=1: all R = 0, Q = 0 (even if FREEZE=1), DIRTY = 0, FSM = IDLE, OUT_VALID = 0, PTR = 0; EN ignored.
  - EN[i]=1 and D_i ≠ R[i]: R[i] ← D_i, DIRTY[i] ← 1.
  - EN[i]=1 and D_i = R[i]: no DIRTY change.
- Q update: FREEZE=0 → Q ← next R (post-write values); FREEZE=1 → Q holds.
- FSM:
  - IDLE, any DIRTY=1: pick the first dirty channel c at or after PTR, wrapping modulo CH. Load OUT_CH=c, OUT_DATA=next R[c], REW=0, OUT_VALID=1; go to PRESENT.
  - PRESENT: OUT_CH and OUT_DATA are held stable. A differing write to channel OUT_CH sets REW=1.
  - PRESENT, OUT_READY=1 (handshake): DIRTY[OUT_CH] is cleared unless REW=1 or a differing write to OUT_CH occurs the same cycle; in those cases it stays 1 (set wins). Then PTR ← (OUT_CH+1) mod CH, OUT_VALID ← 0, go to IDLE.
- PTR wraps from CH-1 to 0; non-power-of-two CH must wrap correctly.
- OUT_VALID never drops without a handshake, except on CLR or reset.

## Timing
- EN/D sampled at edge t → R and DIRTY updated at t; Q visible after edge t when FREEZE=0 at t. Write-to-Q latency is 1 cycle.
- FREEZE sampled per edge. Writes during FREEZE update R and DIRTY, and reach Q on the first edge with FREEZE=0.
- DIRTY set at edge t → OUT_VALID=1 after edge t+1 (IDLE). Latency is 1 cycle from flag to notification.
- Handshake at edge t → OUT_VALID=0 after t; the next notification asserts after edge t+1 at earliest. Peak throughput is 1 notification per 2 cycles.
- No combinational paths from inputs to outputs.
- Reset mid-operation clears everything immediately. Release is synchronous to CLK in the surrounding design.

## Test plan
- Reset then idle: RST_N=0 with random inputs → Q=0, DIRTY=0, OUT_VALID=0. After release with EN=0 for 10 cycles, all outputs stay 0.
- Write/freeze: CH=4, WIDTH=8. EN=4'b0010, D_1=8'hA5 → Q_1=A5 one cycle later. FREEZE=1, write D_1=8'h3C → Q_1 stays A5, DIRTY[1]=1. FREEZE=0 → Q_1=3C next cycle.
- Round-robin: write channels 0, 2, 3 in the same cycle, OUT_READY=1 → notifications on OUT_CH 0, 2, 3 in order, every 2 cycles, with correct OUT_DATA. DIRTY=0 at end.
- Wrap and backpressure: PTR=3 after reporting ch 2; dirty {3,1}; OUT_READY=0 for 5 cycles → OUT_VALID, OUT_CH=3, OUT_DATA held stable. Then ch 3, then ch 1 reported.
- Rewrite during PRESENT: presenting ch 0 with data 11; write ch 0=22 before ack → ack clears nothing. Next notification is ch 0 with OUT_DATA=22. A same-value write (22) produces no further notification.
- CLR in PRESENT with FREEZE=1 → next cycle Q=0, DIRTY=0, OUT_VALID=0. A simultaneous EN write is ignored.

Source files
------------

// File: rtl/d_reg_bank.sv
// Multi-channel D register bank with output freeze, sync clear and round-robin change notification.
// Latency: write-to-Q 1 cycle; dirty-flag-to-notification 1 cycle; peak 1 notification per 2 cycles.
// Backpressure: a notification is held stable until out_ready; only clr or reset withdraw it.
module d_reg_bank #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  localparam int CHW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       en,
  input  logic [CH*WIDTH-1:0] d,
  input  logic                clr,
  input  logic                freeze,
  output logic [CH*WIDTH-1:0] q,
  output logic [CH-1:0]       dirty,
  output logic                out_valid,
  output logic [CHW-1:0]      out_ch,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_ready
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   r      [CH];
  logic [WIDTH-1:0]   r_next [CH];
  logic [CH*WIDTH-1:0] r_next_flat;
  logic [CH-1:0]      wr_diff;
  logic [CH-1:0]      dirty_next;
  logic [CHW-1:0]     ptr;
  logic               rew;
  logic               hs;
  logic [CHW-1:0]     sel_idx;
  logic               sel_found;
  int                 rank;
  int                 best;

  // Post-write store contents; only writes that change a value count as changes.
  always_comb begin
    r_next      = r;
    wr_diff     = '0;
    r_next_flat = '0;
    for (int i = 0; i < CH; i++) begin
      if (clr) begin
        r_next[i] = '0;
      end else if (en[i] && (d[i*WIDTH +: WIDTH] != r[i])) begin
        wr_diff[i] = 1'b1;
        r_next[i]  = d[i*WIDTH +: WIDTH];
      end
      r_next_flat[i*WIDTH +: WIDTH] = r_next[i];
    end
  end

  // Dirty flags: a fresh differing write (or an earlier rewrite) beats the handshake clear.
  always_comb begin
    hs         = (state == PRESENT) && out_ready;
    dirty_next = dirty;
    if (hs && !rew && !wr_diff[out_ch]) begin
      dirty_next[out_ch] = 1'b0;
    end
    dirty_next = dirty_next | wr_diff;
    if (clr) begin
      dirty_next = '0;
    end
  end

  // Round-robin pick: dirty channel with the smallest distance forward from ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best      = CH;
    rank      = 0;
    for (int i = 0; i < CH; i++) begin
      rank = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + CH - int'(ptr));
      if (dirty[i] && (rank < best)) begin
        best      = rank;
        sel_idx   = CHW'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Channel store, frozen-able output copy and dirty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r[i] <= '0;
      end
      q     <= '0;
      dirty <= '0;
    end else begin
      r     <= r_next;
      dirty <= dirty_next;
      if (clr) begin
        q <= '0;
      end else if (!freeze) begin
        q <= r_next_flat;
      end
    end
  end

  // Notification FSM with registered outputs; presented channel/data stay put until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      ptr       <= '0;
      rew       <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ptr       <= '0;
      rew       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            out_ch    <= sel_idx;
            out_data  <= r_next[sel_idx];
            rew       <= 1'b0;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (wr_diff[out_ch]) begin
            rew <= 1'b1;
          end
          if (out_ready) begin
            ptr       <= (out_ch == CHW'(CH-1)) ? '0 : out_ch + 1'b1;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
